// File: rtl/token_multiplier.sv
// Token rate expander: each input token adds `mult` pending output tokens to a
// saturating counter that drains one token per ready cycle; lost tokens set a sticky flag.
module token_multiplier #(
  parameter int CNT_W  = 4,
  parameter int MULT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic [MULT_W-1:0] mult,
  input  logic              b_ready,
  input  logic              ovf_clr,
  output logic              b,
  output logic [CNT_W-1:0]  level,
  output logic              overflow
);

  localparam int SUM_W = CNT_W + MULT_W + 1;
  localparam logic [SUM_W-1:0] MAX_EXT = {{(MULT_W + 1){1'b0}}, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             b_s;
  logic [SUM_W-1:0] add_s;
  logic [SUM_W-1:0] sub_s;
  logic [SUM_W-1:0] nxt_s;
  logic             sat_s;

  // Next-count arithmetic, wide enough that add never wraps; b only drains stored tokens
  always_comb begin
    b_s   = 1'b0;
    add_s = {SUM_W{1'b0}};
    sub_s = {SUM_W{1'b0}};
    if (b_ready && (cnt_r != {CNT_W{1'b0}})) begin
      b_s   = 1'b1;
      sub_s = {{(SUM_W - 1){1'b0}}, 1'b1};
    end else begin
      b_s   = 1'b0;
      sub_s = {SUM_W{1'b0}};
    end
    if (a) begin
      add_s = {{(CNT_W + 1){1'b0}}, mult};
    end else begin
      add_s = {SUM_W{1'b0}};
    end
    nxt_s = {{(MULT_W + 1){1'b0}}, cnt_r} + add_s - sub_s;
    sat_s = (nxt_s > MAX_EXT);
  end

  // Pending-count and sticky overflow registers; a new overflow beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      if (sat_s) begin
        cnt_r <= {CNT_W{1'b1}};
        ovf_r <= 1'b1;
      end else begin
        cnt_r <= nxt_s[CNT_W-1:0];
        ovf_r <= ovf_r & ~ovf_clr;
      end
    end
  end

  assign b        = b_s;
  assign level    = cnt_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_token_multiplier.sv
// Directed self-checking bench for token_multiplier (CNT_W=4, MULT_W=3).
module tb_token_multiplier;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic [2:0] mult;
  logic       b_ready;
  logic       ovf_clr;
  logic       b;
  logic [3:0] level;
  logic       overflow;

  int checks;
  int errors;

  token_multiplier #(.CNT_W(4), .MULT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .mult(mult), .b_ready(b_ready),
    .ovf_clr(ovf_clr), .b(b), .level(level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = 1'b0; mult = 3'd0; b_ready = 1'b1; ovf_clr = 1'b0;
    #3;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL reset_b got %0b exp 0", b); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult0_mult1();
    mult = 3'd0; b_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0);
      tick();
      checks++; if (b !== 1'b0 || level !== 4'd0) begin
        errors++; $display("FAIL mult0 cycle %0d got b=%0b level=%0d exp b=0 level=0", i, b, level);
      end
    end
    mult = 3'd1; a = 1'b1;
    #1;
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL mult1_first_b got %0b exp 0", b); end
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) a = 1'b0;
      tick();
      if (i == 10) a = 1'b0;
      checks++; if (level !== ((i <= 10) ? 4'd1 : 4'd0) || b !== (i <= 10)) begin
        errors++; $display("FAIL mult1 cycle %0d got b=%0b level=%0d exp b=%0b level=%0d",
                           i, b, level, (i <= 10), (i <= 10) ? 1 : 0);
      end
    end
  endtask

  task automatic test_doubling();
    int na, nb;
    na = 0; nb = 0;
    mult = 3'd2; b_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = (i < 100) && (((i * 7) % 10) < 3);
      #1;
      if (a) na++;
      if (b) nb++;
      tick();
    end
    a = 1'b0;
    checks++; if (nb !== 2 * na || na !== 30) begin
      errors++; $display("FAIL doubling_count got b=%0d a=%0d exp b=60 a=30", nb, na);
    end
    checks++; if (level !== 4'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL doubling_end got level=%0d ovf=%0b exp 0 0", level, overflow);
    end
  endtask

  task automatic test_backpressure();
    b_ready = 1'b0; mult = 3'd2; a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL bp_hold_b cycle %0d got %0b exp 0", i, b); end
      tick();
    end
    a = 1'b0;
    checks++; if (level !== 4'd10) begin errors++; $display("FAIL bp_level got %0d exp 10", level); end
    b_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (b !== (i < 10)) begin errors++; $display("FAIL bp_drain cycle %0d got %0b exp %0b", i, b, (i < 10)); end
      tick();
    end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL bp_final_level got %0d exp 0", level); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_lvl;
    mult = 3'd3; b_ready = 1'b1; a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_lvl = (k == 8) ? 4'd15 : 4'(2 * k + 1);
      checks++; if (level !== exp_lvl || overflow !== (k == 8)) begin
        errors++; $display("FAIL sat edge %0d got level=%0d ovf=%0b exp level=%0d ovf=%0b",
                           k, level, overflow, exp_lvl, (k == 8));
      end
    end
    a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_hold cycle %0d got %0b exp 1", i, overflow); end
    end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL sat_drained got %0d exp 0", level); end
  endtask

  task automatic test_overflow_clear();
    a = 1'b0; b_ready = 1'b1; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_plain got %0b exp 0", overflow); end
    b_ready = 1'b0; a = 1'b1; mult = 3'd7;
    tick(); tick();
    checks++; if (level !== 4'd14 || overflow !== 1'b0) begin
      errors++; $display("FAIL clr_fill got level=%0d ovf=%0b exp 14 0", level, overflow);
    end
    tick();
    checks++; if (level !== 4'd15 || overflow !== 1'b1) begin
      errors++; $display("FAIL clr_sat got level=%0d ovf=%0b exp 15 1", level, overflow);
    end
    mult = 3'd1; ovf_clr = 1'b1;
    tick();
    checks++; if (level !== 4'd15 || overflow !== 1'b1) begin
      errors++; $display("FAIL clr_set_wins got level=%0d ovf=%0b exp 15 1", level, overflow);
    end
    a = 1'b0;
    tick();
    ovf_clr = 1'b0;
    checks++; if (level !== 4'd15 || overflow !== 1'b0) begin
      errors++; $display("FAIL clr_after got level=%0d ovf=%0b exp 15 0", level, overflow);
    end
  endtask

  task automatic test_async_reset();
    b_ready = 1'b0; a = 1'b1; mult = 3'd1;
    tick();
    a = 1'b0; b_ready = 1'b1;
    repeat (6) tick();
    checks++; if (level !== 4'd9 || overflow !== 1'b1) begin
      errors++; $display("FAIL ar_setup got level=%0d ovf=%0b exp 9 1", level, overflow);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (level !== 4'd0 || b !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL ar_immediate got level=%0d b=%0b ovf=%0b exp 0 0 0", level, b, overflow);
    end
    #10 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL ar_no_b cycle %0d got %0b exp 0", i, b); end
    end
    a = 1'b1; mult = 3'd1;
    tick();
    a = 1'b0;
    checks++; if (b !== 1'b1 || level !== 4'd1) begin
      errors++; $display("FAIL ar_new_token got b=%0b level=%0d exp 1 1", b, level);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult0_mult1();
    test_doubling();
    test_backpressure();
    test_saturation();
    test_overflow_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/token_multiplier.md
# token_multiplier

Parametrised successor to the fixed ×2 token doubler. It converts each single-cycle input token into `mult` output tokens, where `mult` is a runtime factor sampled with every token. It holds outstanding output tokens in a saturating counter, honours downstream backpressure, and flags lost tokens with a sticky, clearable overflow. It sits between a token producer and a consumer that issues one token per cycle, for example a rate expander feeding a credit or pulse stream.

## Interface
Parameters:
- `CNT_W`, default 4: pending-token counter width. Maximum pending count is MAX = 2^CNT_W − 1.
- `MULT_W`, default 3: width of the runtime multiplication factor.

Ports:
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `a` input, 1 bit: input token. One token per cycle in which `a` = 1.
- `mult` input, MULT_W bits: tokens to emit per input token. Sampled only in cycles where `a` = 1.
- `b_ready` input, 1 bit: consumer can accept a token this cycle.
- `ovf_clr` input, 1 bit: synchronous clear of the sticky overflow.
- `b` output, 1 bit: output token. Combinational: `b` = `b_ready` & (`cnt` ≠ 0).
- `level` output, CNT_W bits: current pending count `cnt`, registered.
- `overflow` output, 1 bit: sticky flag, registered. Set when tokens have been lost.

## Operation
- Internal state:
  - `cnt`, CNT_W bits.
  - `overflow`, 1 bit.
- Each cycle, the unsaturated next count is computed in CNT_W+MULT_W+1 bits, with no wrap:
  - nxt = `cnt` + (`a` ? `mult` : 0) − (`b` ? 1 : 0)
- Counter update:
  - If nxt ≤ MAX: `cnt` ← nxt.
  - If nxt > MAX: `cnt` ← MAX, `overflow` ← 1. The excess tokens are dropped.
- `b` emits only from tokens already in `cnt`. Tokens arriving this cycle are not bypassed, so nxt can never go negative.
- Overflow flag:
  - When `ovf_clr` = 1 and no new overflow occurs this cycle, `overflow` ← 0.
  - When both happen in the same cycle, set wins.
- `mult` = 0: the token is consumed with no output tokens and no error.
- `mult` = 1: pass-through with one cycle of latency.
- Simultaneous `a` and `b`: add and subtract apply in the same cycle. At `cnt` = MAX with `b` = 1, a token with `mult` = 1 does not overflow.
- `b_ready` = 0: `cnt` holds or grows. There is no timeout.

## Timing
- Reset, asynchronous on `rst_n` low:
  - `cnt` = 0, `overflow` = 0.
  - Therefore `level` = 0 and `b` = 0 immediately, independent of `clk`.
- Reset asserted mid-operation discards all pending tokens. No `b` is issued after `rst_n` rises until a new `a` arrives.
- Latency: a token on `a` in cycle t gives its first `b` in cycle t+1 if `b_ready` is high. It then gives `b` on each subsequent ready cycle until `mult` tokens are issued.
- Throughput: at most one `b` per cycle. Sustained input rate × `mult` greater than 1 eventually overflows.
- `overflow` becomes visible the cycle after the offending input. `level` reads MAX in that same cycle.
- Conservation: in any window starting and ending with `cnt` = 0 and no overflow, count(`b`) = Σ `mult` over the `a` cycles in the window.

## Test plan
All scenarios use CNT_W = 4, MULT_W = 3.
- **Random doubling:** `mult` = 2, `b_ready` = 1, 100 cycles with `a` random at 30%, then `a` = 0 for 200 cycles. Expect count(`b`) = 2 × count(`a`), `overflow` = 0 and `level` = 0 at the end.
- **Saturation:** `mult` = 3, `b_ready` = 1, `a` = 1 continuously from `level` = 0. Expect `level` to go 3, 5, 7, …, 15 after edge 7. At edge 8, nxt = 17, so `level` stays 15 and `overflow` = 1. The flag holds through 20 more cycles.
- **Backpressure:** `b_ready` = 0, five tokens with `mult` = 2. Expect `level` = 10 and `b` = 0 throughout. Then raise `b_ready`: expect `b` high for exactly 10 consecutive cycles, then `level` = 0.
- **mult = 0 and mult = 1:**
  - `mult` = 0 with `a` pulses: expect `b` never asserts and `level` stays 0.
  - `mult` = 1 with `a` = 1 for 10 cycles: expect `level` = 1 steady and `b` high from the cycle after the first `a` for exactly 10 cycles.
- **Overflow clear:** force overflow, then pulse `ovf_clr` with `a` = 0: expect `overflow` = 0 on the next cycle. Then pulse `ovf_clr` in a cycle that also overflows: expect `overflow` stays 1.
- **Async reset mid-run:** with `level` = 9, drop `rst_n` between clock edges. Expect `level` = 0, `b` = 0 and `overflow` = 0 immediately. After release, no `b` appears until a new `a`.
